ring_decode: RTL and testbench

//  Receive-side checker/decoder for a WIDTH-bit one-hot rotating ring pattern: a single 1 advancing LSB->MSB, with the MSB wrapping to bit 0.

---
 rtl/ring_decode.sv | 151 +++++++++++++++
 tb/tb_ring_decode.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ring_decode.sv
// Receive-side checker for a one-hot rotating ring: synchronises, deglitches and decodes
// the pattern, tracks legal rotation, and reports lock, steps, revolutions and errors.
module ring_decode #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE      = 3,
    parameter int LOCK_COUNT  = 4,
    parameter int REV_W       = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     clear_err,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     valid,
    output logic                     step,
    output logic                     locked,
    output logic                     err,
    output logic                     err_sticky,
    output logic [REV_W-1:0]         rev_count
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam int GC_W  = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE - 1);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    logic [WIDTH-1:0] sync_p0 [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] cand_p1;
    logic [CNT_W-1:0] stable_cnt_p1;
    logic [WIDTH-1:0] acc_p2;
    logic [GC_W-1:0]  good_cnt;
    state_t           state;

    logic eval_p1;
    logic onehot;
    logic legal;

    function automatic logic is_onehot(input logic [WIDTH-1:0] n);
        return (n != '0) && ((n & (n - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] enc_index(input logic [WIDTH-1:0] n);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (n[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Stage p0: multi-flop synchroniser on the asynchronous ring input
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p0[i] <= '0;
        end else begin
            sync_p0[0] <= ring_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p0[i] <= sync_p0[i-1];
        end
    end

    assign s = sync_p0[SYNC_STAGES-1];

    // Stage p1: candidate and stability counter; any change restarts the count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cand_p1       <= '0;
            stable_cnt_p1 <= '0;
        end else begin
            cand_p1       <= s;
            stable_cnt_p1 <= (s != cand_p1) ? '0 : sat_inc(stable_cnt_p1);
        end
    end

    assign eval_p1 = (s == cand_p1) && (stable_cnt_p1 == CNT_MAX) && (s != acc_p2);
    assign onehot  = is_onehot(s);
    assign legal   = onehot && (s == {acc_p2[WIDTH-2:0], acc_p2[WIDTH-1]});

    // Stage p2: accepted pattern, lock state machine and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_p2     <= '0;
            state      <= SEARCH;
            good_cnt   <= '0;
            index      <= '0;
            valid      <= 1'b0;
            step       <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            rev_count  <= '0;
        end else begin
            step <= 1'b0;
            err  <= 1'b0;
            // A same-cycle error assignment below overrides this clear
            if (clear_err) err_sticky <= 1'b0;
            if (eval_p1) begin
                acc_p2 <= s;
                valid  <= onehot;
                if (onehot) index <= enc_index(s);
                case (state)
                    SEARCH: begin
                        if (onehot) begin
                            state    <= TRACK;
                            good_cnt <= '0;
                        end
                    end
                    TRACK: begin
                        if (legal) begin
                            step     <= 1'b1;
                            good_cnt <= good_cnt + GC_W'(1);
                            if (good_cnt == GC_W'(LOCK_COUNT - 1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (onehot) begin
                            good_cnt <= '0;
                        end else begin
                            state    <= SEARCH;
                            good_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (legal) begin
                            step <= 1'b1;
                            if (acc_p2[WIDTH-1]) rev_count <= rev_count + REV_W'(1);
                        end else begin
                            err        <= 1'b1;
                            err_sticky <= 1'b1;
                            locked     <= 1'b0;
                            good_cnt   <= '0;
                            state      <= onehot ? TRACK : SEARCH;
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        good_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_decode.sv
// Directed bench for ring_decode: a vector table of held ring patterns with expected
// outputs and pulse counts, plus hand-written reset, wrap and clear/error sequences.
module tb_ring_decode;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ring_in;
    logic       clear_err;
    logic [1:0] index;
    logic       valid, step, locked, err, err_sticky;
    logic [3:0] rev_count;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    ring_decode #(
        .WIDTH(4), .SYNC_STAGES(2), .STABLE(3), .LOCK_COUNT(4), .REV_W(4)
    ) dut (
        .clock(clk), .reset(reset), .ring_in(ring_in), .clear_err(clear_err),
        .index(index), .valid(valid), .step(step), .locked(locked),
        .err(err), .err_sticky(err_sticky), .rev_count(rev_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ring;
        int         hold;
        logic       clr;
        logic [1:0] idx;
        logic       vld;
        int         steps;
        logic       lk;
        int         errs;
        logic       sticky;
        logic [3:0] rev;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] ring, input int hold, input logic clr,
                                input logic [1:0] idx, input logic vld, input int steps,
                                input logic lk, input int errs, input logic sticky,
                                input logic [3:0] rev);
        vec_t v;
        v.ring = ring; v.hold = hold; v.clr = clr; v.idx = idx; v.vld = vld;
        v.steps = steps; v.lk = lk; v.errs = errs; v.sticky = sticky; v.rev = rev;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0d, expected %0d", name, tag, act, exp);
        end
    endtask

    task automatic run_window(input int n, output int st, output int er);
        st = 0;
        er = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (step) st++;
            if (err) er++;
            if (step && err) overlap++;
        end
    endtask

    task automatic drive(input logic [3:0] p, input int n, output int st, output int er);
        @(posedge clk);
        #1 ring_in = p;
        run_window(n, st, er);
    endtask

    initial begin
        int st, er, tot_st, tot_er;

        // Test 1: lock onto a clean rotation
        add(4'b0001, 10, 0, 0, 1, 0, 0, 0, 0, 0);
        add(4'b0010, 10, 0, 1, 1, 1, 0, 0, 0, 0);
        add(4'b0100, 10, 0, 2, 1, 1, 0, 0, 0, 0);
        add(4'b1000, 10, 0, 3, 1, 1, 0, 0, 0, 0);
        add(4'b0001, 10, 0, 0, 1, 1, 1, 0, 0, 0);
        add(4'b0010, 10, 0, 1, 1, 1, 1, 0, 0, 0);
        add(4'b0100, 10, 0, 2, 1, 1, 1, 0, 0, 0);
        add(4'b1000, 10, 0, 3, 1, 1, 1, 0, 0, 0);
        add(4'b0001, 10, 0, 0, 1, 1, 1, 0, 0, 1);
        // Test 2: illegal jump while locked, relock, then clear_err
        add(4'b0010, 10, 0, 1, 1, 1, 1, 0, 0, 1);
        add(4'b1000, 10, 0, 3, 1, 0, 0, 1, 1, 1);
        add(4'b0001, 10, 0, 0, 1, 1, 0, 0, 1, 1);
        add(4'b0010, 10, 0, 1, 1, 1, 0, 0, 1, 1);
        add(4'b0100, 10, 0, 2, 1, 1, 0, 0, 1, 1);
        add(4'b1000, 10, 0, 3, 1, 1, 1, 0, 1, 1);
        add(4'b0001, 10, 0, 0, 1, 1, 1, 0, 1, 2);
        add(4'b0001, 10, 1, 0, 1, 0, 1, 0, 0, 2);
        // Test 3: short glitch is ignored
        add(4'b0010, 10, 0, 1, 1, 1, 1, 0, 0, 2);
        add(4'b0100, 10, 0, 2, 1, 1, 1, 0, 0, 2);
        add(4'b0011,  2, 0, 2, 1, 0, 1, 0, 0, 2);
        add(4'b1000, 10, 0, 3, 1, 1, 1, 0, 0, 2);
        add(4'b0001, 10, 0, 0, 1, 1, 1, 0, 0, 3);
        // Test 4: all-zero while locked, back to SEARCH, TRACK resets on illegal one-hot
        add(4'b0000, 10, 0, 0, 0, 0, 0, 1, 1, 3);
        add(4'b0001, 10, 0, 0, 1, 0, 0, 0, 1, 3);
        add(4'b0010, 10, 0, 1, 1, 1, 0, 0, 1, 3);
        add(4'b1000, 10, 0, 3, 1, 0, 0, 0, 1, 3);
        add(4'b0001, 10, 0, 0, 1, 1, 0, 0, 1, 3);
        add(4'b0010, 10, 0, 1, 1, 1, 0, 0, 1, 3);
        add(4'b0100, 10, 0, 2, 1, 1, 0, 0, 1, 3);
        add(4'b1000, 10, 0, 3, 1, 1, 1, 0, 1, 3);
        add(4'b0001, 10, 0, 0, 1, 1, 1, 0, 1, 4);
        add(4'b0010, 10, 0, 1, 1, 1, 1, 0, 1, 4);
        add(4'b0100, 10, 0, 2, 1, 1, 1, 0, 1, 4);
        add(4'b1000, 10, 0, 3, 1, 1, 1, 0, 1, 4);
        add(4'b0001, 10, 0, 0, 1, 1, 1, 0, 1, 5);

        reset = 1'b0;
        ring_in = 4'b0101;
        clear_err = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_outputs", -1,
              int'({index, valid, step, locked, err, err_sticky, rev_count}), 0);
        ring_in = 4'b0000;
        @(posedge clk);
        #1 reset = 1'b1;
        run_window(8, st, er);
        check("idle_after_reset", -1, int'({valid, step, locked, err}), 0);

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            #1;
            ring_in = vecs[k].ring;
            clear_err = vecs[k].clr;
            run_window(vecs[k].hold, st, er);
            clear_err = 1'b0;
            check("index", k, int'(index), int'(vecs[k].idx));
            check("valid", k, int'(valid), int'(vecs[k].vld));
            check("step_pulses", k, st, vecs[k].steps);
            check("locked", k, int'(locked), int'(vecs[k].lk));
            check("err_pulses", k, er, vecs[k].errs);
            check("err_sticky", k, int'(err_sticky), int'(vecs[k].sticky));
            check("rev_count", k, int'(rev_count), int'(vecs[k].rev));
        end

        // Test 5: asynchronous reset mid-operation while locked with rev_count=5
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("async_reset_outputs", 100,
                 int'({index, valid, step, locked, err, err_sticky, rev_count}), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        run_window(10, st, er);
        check("post_reset_valid", 101, int'(valid), 1);
        check("post_reset_index", 101, int'(index), 0);
        check("post_reset_steps", 101, st, 0);
        check("post_reset_locked", 101, int'(locked), 0);

        // Test 6: relock, then 16 counted wraps to roll the 4-bit counter over
        tot_st = 0;
        tot_er = 0;
        for (int r = 0; r < 17; r++) begin
            drive(4'b0010, 8, st, er); tot_st += st; tot_er += er;
            drive(4'b0100, 8, st, er); tot_st += st; tot_er += er;
            drive(4'b1000, 8, st, er); tot_st += st; tot_er += er;
            drive(4'b0001, 8, st, er); tot_st += st; tot_er += er;
            if (r == 0) check("relock", 200, int'(locked), 1);
            if (r == 15) check("rev_before_wrap", 200, int'(rev_count), 15);
        end
        check("rev_after_wrap", 201, int'(rev_count), 0);
        check("wrap_total_steps", 201, tot_st, 68);
        check("wrap_total_errs", 201, tot_er, 0);
        check("sticky_clear_before", 201, int'(err_sticky), 0);

        // clear_err coincident with a new error: the error must win
        @(posedge clk);
        #1 ring_in = 4'b0100;
        run_window(6, st, er);
        check("err_latency_early", 202, er, 0);
        clear_err = 1'b1;
        @(negedge clk);
        check("err_pulse", 202, int'(err), 1);
        check("sticky_error_wins", 202, int'(err_sticky), 1);
        check("unlock_on_err", 202, int'(locked), 0);
        clear_err = 1'b0;
        @(negedge clk);
        check("err_one_cycle", 203, int'(err), 0);
        check("sticky_holds", 203, int'(err_sticky), 1);

        check("step_err_overlap", 204, overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
